// File: rtl/lcd_msg_pkg.sv
// Message codes and 16-character line texts for the shared parking LCD.
package lcd_msg_pkg;

  localparam logic [2:0] MSG_IDLE      = 3'd0;
  localparam logic [2:0] MSG_WELCOME   = 3'd1;
  localparam logic [2:0] MSG_FULL      = 3'd2;
  localparam logic [2:0] MSG_ENTER_KEY = 3'd3;
  localparam logic [2:0] MSG_WRONG_KEY = 3'd4;
  localparam logic [2:0] MSG_GATE_OPEN = 3'd5;

  // Each literal is exactly 16 characters, MSB = leftmost character.
  localparam logic [127:0] TXT_IDLE_L1      = "Parking Ready   ";
  localparam logic [127:0] TXT_IDLE_L2      = "Spaces Avail    ";
  localparam logic [127:0] TXT_WELCOME_L1   = "Welcome!        ";
  localparam logic [127:0] TXT_WELCOME_L2   = "Please Enter Key";
  localparam logic [127:0] TXT_FULL_L1      = "Parking Full    ";
  localparam logic [127:0] TXT_FULL_L2      = "Please Wait     ";
  localparam logic [127:0] TXT_ENTER_KEY_L1 = "Enter Pass Key  ";
  localparam logic [127:0] TXT_ENTER_KEY_L2 = "Then Press OK   ";
  localparam logic [127:0] TXT_WRONG_KEY_L1 = "Wrong Pass Key  ";
  localparam logic [127:0] TXT_WRONG_KEY_L2 = "Try Again       ";
  localparam logic [127:0] TXT_GATE_OPEN_L1 = "Gate Open       ";
  localparam logic [127:0] TXT_GATE_OPEN_L2 = "Drive Safely    ";
  localparam logic [127:0] TXT_BLANK        = {16{8'h20}};

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// Request/grant and display bus between the requesters and the LCD scheduler.
interface lcd_msg_scheduler_if #(
  parameter int unsigned N_REQ = 4
) ();
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   iREQ;
  logic [3*N_REQ-1:0] iMSG;
  logic [N_REQ-1:0]   oGNT;
  logic [127:0]       oLINE1;
  logic [127:0]       oLINE2;
  logic               oUPDATE;
  logic               oBUSY;
  logic [ID_W-1:0]    oCUR_ID;

  modport master (
    output iREQ, iMSG,
    input  oGNT, oLINE1, oLINE2, oUPDATE, oBUSY, oCUR_ID
  );

  modport slave (
    input  iREQ, iMSG,
    output oGNT, oLINE1, oLINE2, oUPDATE, oBUSY, oCUR_ID
  );
endinterface

// File: rtl/lcd_msg_rom.sv
// Combinational message-code to two-line text lookup; unused codes show blanks.
module lcd_msg_rom
  import lcd_msg_pkg::*;
(
  input  logic [2:0]   code,
  output logic [127:0] line1,
  output logic [127:0] line2
);
  always_comb begin
    line1 = TXT_BLANK;
    line2 = TXT_BLANK;
    case (code)
      MSG_IDLE:      begin line1 = TXT_IDLE_L1;      line2 = TXT_IDLE_L2;      end
      MSG_WELCOME:   begin line1 = TXT_WELCOME_L1;   line2 = TXT_WELCOME_L2;   end
      MSG_FULL:      begin line1 = TXT_FULL_L1;      line2 = TXT_FULL_L2;      end
      MSG_ENTER_KEY: begin line1 = TXT_ENTER_KEY_L1; line2 = TXT_ENTER_KEY_L2; end
      MSG_WRONG_KEY: begin line1 = TXT_WRONG_KEY_L1; line2 = TXT_WRONG_KEY_L2; end
      MSG_GATE_OPEN: begin line1 = TXT_GATE_OPEN_L1; line2 = TXT_GATE_OPEN_L2; end
      default:       ;
    endcase
  end
endmodule

// File: rtl/lcd_msg_scheduler.sv
// Fixed-priority, preemptive scheduler sharing the 16x2 LCD between requesters.
module lcd_msg_scheduler
  import lcd_msg_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  lcd_msg_scheduler_if.slave  bus
);
  localparam int unsigned      ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_SHOW} state_e;

  state_e           state;
  logic [N_REQ-1:0] gnt_q;
  logic [127:0]     line1_q;
  logic [127:0]     line2_q;
  logic             upd_q;
  logic             busy_q;
  logic [ID_W-1:0]  cur_q;
  logic [CNT_W-1:0] cnt_q;

  logic             any_req;
  logic             pre_req;
  logic             do_grant;
  logic             do_release;
  logic [ID_W-1:0]  win_id;
  logic [N_REQ-1:0] win_oh;
  logic [2:0]       win_code;
  logic [127:0]     rom_l1;
  logic [127:0]     rom_l2;

  // Scanning from the top down leaves the lowest set index as the winner.
  always_comb begin
    win_id   = '0;
    win_oh   = '0;
    win_code = '0;
    pre_req  = 1'b0;
    any_req  = |bus.iREQ;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (bus.iREQ[i-1]) begin
        win_id       = ID_W'(i - 1);
        win_oh       = '0;
        win_oh[i-1]  = 1'b1;
        win_code     = bus.iMSG[3*(i-1) +: 3];
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (bus.iREQ[i] && (ID_W'(i) < cur_q)) pre_req = 1'b1;
    end
  end

  always_comb begin
    do_grant   = 1'b0;
    do_release = 1'b0;
    if (state == S_IDLE) begin
      do_grant = any_req;
    end else begin
      do_grant   = pre_req || ((cnt_q == '0) && any_req);
      do_release = (cnt_q == '0) && !any_req;
    end
  end

  lcd_msg_rom u_rom (
    .code  (win_code),
    .line1 (rom_l1),
    .line2 (rom_l2)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= S_IDLE;
      gnt_q   <= '0;
      line1_q <= TXT_IDLE_L1;
      line2_q <= TXT_IDLE_L2;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      gnt_q <= '0;
      upd_q <= 1'b0;
      if (do_grant) begin
        state   <= S_SHOW;
        gnt_q   <= win_oh;
        line1_q <= rom_l1;
        line2_q <= rom_l2;
        upd_q   <= 1'b1;
        busy_q  <= 1'b1;
        cur_q   <= win_id;
        cnt_q   <= HOLD_LOAD;
      end else if (do_release) begin
        state   <= S_IDLE;
        line1_q <= TXT_IDLE_L1;
        line2_q <= TXT_IDLE_L2;
        upd_q   <= 1'b1;
        busy_q  <= 1'b0;
        cur_q   <= '0;
      end else if (state == S_SHOW) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign bus.oGNT    = gnt_q;
  assign bus.oLINE1  = line1_q;
  assign bus.oLINE2  = line2_q;
  assign bus.oUPDATE = upd_q;
  assign bus.oBUSY   = busy_q;
  assign bus.oCUR_ID = cur_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Scenario tasks plus a randomized run against a time-remaining reference model.
module tb_lcd_msg_scheduler;
  localparam int HOLD = 8;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  lcd_msg_scheduler_if #(.N_REQ(4)) bus ();

  lcd_msg_scheduler #(
    .N_REQ       (4),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (26)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] ref_l1(input logic [2:0] c);
    case (c)
      3'd0:    return "Parking Ready   ";
      3'd1:    return "Welcome!        ";
      3'd2:    return "Parking Full    ";
      3'd3:    return "Enter Pass Key  ";
      3'd4:    return "Wrong Pass Key  ";
      3'd5:    return "Gate Open       ";
      default: return {16{8'h20}};
    endcase
  endfunction

  function automatic logic [127:0] ref_l2(input logic [2:0] c);
    case (c)
      3'd0:    return "Spaces Avail    ";
      3'd1:    return "Please Enter Key";
      3'd2:    return "Please Wait     ";
      3'd3:    return "Then Press OK   ";
      3'd4:    return "Try Again       ";
      3'd5:    return "Drive Safely    ";
      default: return {16{8'h20}};
    endcase
  endfunction

  // Reference model: owner index (-1 = idle) and display cycles still owed to it.
  int           m_owner;
  int           m_left;
  logic [3:0]   e_gnt;
  logic         e_upd;
  logic         e_busy;
  logic [1:0]   e_id;
  logic [127:0] e_l1;
  logic [127:0] e_l2;

  always @(posedge clk or negedge rst_n) begin : ref_model
    int w;
    w = -1;
    if (!rst_n) begin
      m_owner = -1;
      m_left  = 0;
      e_gnt   = '0;
      e_upd   = 1'b0;
      e_busy  = 1'b0;
      e_id    = '0;
      e_l1    = ref_l1(3'd0);
      e_l2    = ref_l2(3'd0);
    end else begin
      for (int k = 3; k >= 0; k--) if (bus.iREQ[k]) w = k;
      e_gnt = '0;
      e_upd = 1'b0;
      if (m_owner >= 0) m_left = m_left - 1;
      if (w >= 0 && (m_owner < 0 || w < m_owner || m_left == 0)) begin
        m_owner = w;
        m_left  = HOLD;
        e_gnt   = 4'(1 << w);
        e_upd   = 1'b1;
        e_busy  = 1'b1;
        e_id    = 2'(w);
        e_l1    = ref_l1(bus.iMSG[3*w +: 3]);
        e_l2    = ref_l2(bus.iMSG[3*w +: 3]);
      end else if (m_owner >= 0 && m_left == 0) begin
        m_owner = -1;
        e_upd   = 1'b1;
        e_busy  = 1'b0;
        e_id    = '0;
        e_l1    = ref_l1(3'd0);
        e_l2    = ref_l2(3'd0);
      end
    end
  end

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.iREQ = '0;
    bus.iMSG = '0;
    @(negedge clk);
    checks++;
    if (bus.oLINE1 !== ref_l1(3'd0) || bus.oLINE2 !== ref_l2(3'd0)) begin
      errors++;
      $display("FAIL reset_lines: got '%s'/'%s' want '%s'/'%s'", bus.oLINE1, bus.oLINE2, ref_l1(3'd0), ref_l2(3'd0));
    end
    checks++;
    if ({bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b id=%0d busy=%b upd=%b want all 0", bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oUPDATE !== 1'b0 || bus.oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got upd=%b busy=%b want 0 0", bus.oUPDATE, bus.oBUSY);
    end
  endtask

  task automatic test_single();
    int  shown;
    logic extra;
    bus.iMSG[8:6] = 3'd4;
    bus.iREQ      = 4'b0100;
    @(negedge clk);
    checks++;
    if ({bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE} !== {4'b0100, 2'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b id=%0d busy=%b upd=%b want 0100 2 1 1", bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE);
    end
    checks++;
    if (bus.oLINE1 !== "Wrong Pass Key  ") begin
      errors++;
      $display("FAIL single_text: got '%s' want 'Wrong Pass Key  '", bus.oLINE1);
    end
    bus.iREQ = '0;
    shown = 1;
    extra = 1'b0;
    for (int i = 0; i < 20 && bus.oBUSY; i++) begin
      @(negedge clk);
      if (bus.oBUSY) shown++;
      if (bus.oGNT !== 4'b0000) extra = 1'b1;
    end
    checks++;
    if (shown != HOLD || extra) begin
      errors++;
      $display("FAIL single_hold: got %0d cycles (stray gnt=%b) want %0d", shown, extra, HOLD);
    end
    checks++;
    if (bus.oLINE1 !== ref_l1(3'd0) || bus.oUPDATE !== 1'b1 || bus.oCUR_ID !== 2'd0) begin
      errors++;
      $display("FAIL single_return: got '%s' upd=%b id=%0d want idle text upd=1 id=0", bus.oLINE1, bus.oUPDATE, bus.oCUR_ID);
    end
  endtask

  task automatic test_simultaneous();
    int bad;
    bus.iMSG[5:3]  = 3'd1;
    bus.iMSG[11:9] = 3'd5;
    bus.iREQ       = 4'b1010;
    @(negedge clk);
    checks++;
    if ({bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE} !== {4'b0010, 2'd1, 1'b1, 1'b1} ||
        bus.oLINE1 !== "Welcome!        ") begin
      errors++;
      $display("FAIL simul_first: got gnt=%b id=%0d '%s' want 0010 1 'Welcome!'", bus.oGNT, bus.oCUR_ID, bus.oLINE1);
    end
    bus.iREQ[1] = 1'b0;
    bad = 0;
    for (int i = 1; i < HOLD; i++) begin
      @(negedge clk);
      if (bus.oGNT !== 4'b0000 || bus.oBUSY !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL simul_wait: got %0d disturbed hold cycles want 0", bad);
    end
    @(negedge clk);
    checks++;
    if ({bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE} !== {4'b1000, 2'd3, 1'b1, 1'b1} ||
        bus.oLINE1 !== "Gate Open       ") begin
      errors++;
      $display("FAIL simul_second: got gnt=%b id=%0d busy=%b '%s' want 1000 3 1 'Gate Open'", bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oLINE1);
    end
    bus.iREQ[3] = 1'b0;
    for (int i = 0; i < 20 && bus.oBUSY; i++) @(negedge clk);
    checks++;
    if (bus.oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL simul_idle: got busy=%b want 0", bus.oBUSY);
    end
  endtask

  task automatic test_preempt();
    int shown;
    bus.iMSG[11:9] = 3'd2;
    bus.iREQ       = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus.oGNT !== 4'b1000 || bus.oLINE1 !== "Parking Full    ") begin
      errors++;
      $display("FAIL preempt_first: got gnt=%b '%s' want 1000 'Parking Full'", bus.oGNT, bus.oLINE1);
    end
    bus.iREQ = '0;
    repeat (3) @(negedge clk);
    bus.iMSG[2:0] = 3'd3;
    bus.iREQ      = 4'b0001;
    @(negedge clk);
    checks++;
    if ({bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE} !== {4'b0001, 2'd0, 1'b1, 1'b1} ||
        bus.oLINE1 !== "Enter Pass Key  ") begin
      errors++;
      $display("FAIL preempt_grant: got gnt=%b id=%0d upd=%b '%s' want 0001 0 1 'Enter Pass Key'", bus.oGNT, bus.oCUR_ID, bus.oUPDATE, bus.oLINE1);
    end
    bus.iREQ = '0;
    shown = 1;
    for (int i = 0; i < 20 && bus.oBUSY; i++) begin
      @(negedge clk);
      if (bus.oBUSY) shown++;
    end
    checks++;
    if (shown != HOLD || bus.oLINE1 !== ref_l1(3'd0)) begin
      errors++;
      $display("FAIL preempt_hold: got %0d cycles then '%s' want %0d then idle", shown, bus.oLINE1, HOLD);
    end
  endtask

  task automatic test_nonpreempt();
    int bad;
    bus.iMSG[5:3] = 3'd1;
    bus.iREQ      = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus.oGNT !== 4'b0010) begin
      errors++;
      $display("FAIL nonpre_first: got gnt=%b want 0010", bus.oGNT);
    end
    bus.iREQ = '0;
    @(negedge clk);
    bus.iMSG[8:6] = 3'd5;
    bus.iREQ      = 4'b0100;
    bad = 0;
    for (int i = 0; i < HOLD - 2; i++) begin
      @(negedge clk);
      if (bus.oGNT !== 4'b0000 || bus.oCUR_ID !== 2'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nonpre_wait: got %0d early grants/owner changes want 0", bad);
    end
    @(negedge clk);
    checks++;
    if ({bus.oGNT, bus.oCUR_ID, bus.oUPDATE} !== {4'b0100, 2'd2, 1'b1} || bus.oLINE1 !== "Gate Open       ") begin
      errors++;
      $display("FAIL nonpre_grant: got gnt=%b id=%0d upd=%b '%s' want 0100 2 1 'Gate Open'", bus.oGNT, bus.oCUR_ID, bus.oUPDATE, bus.oLINE1);
    end
    bus.iREQ = '0;
    for (int i = 0; i < 20 && bus.oBUSY; i++) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.iMSG[2:0] = 3'd7;
    bus.iREQ      = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.oGNT !== 4'b0001 || bus.oLINE1 !== {16{8'h20}} || bus.oLINE2 !== {16{8'h20}}) begin
      errors++;
      $display("FAIL unknown_code: got gnt=%b '%s'/'%s' want 0001 and 32 spaces", bus.oGNT, bus.oLINE1, bus.oLINE2);
    end
    bus.iREQ      = 4'b0000;
    bus.iMSG[8:6] = 3'd4;
    bus.iREQ      = 4'b0100;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE} !== 8'h00 ||
        bus.oLINE1 !== ref_l1(3'd0) || bus.oLINE2 !== ref_l2(3'd0)) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b id=%0d busy=%b upd=%b '%s' want zeros and idle text", bus.oGNT, bus.oCUR_ID, bus.oBUSY, bus.oUPDATE, bus.oLINE1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.oGNT, bus.oCUR_ID} !== {4'b0100, 2'd2} || bus.oLINE1 !== "Wrong Pass Key  ") begin
      errors++;
      $display("FAIL reset_resample: got gnt=%b id=%0d '%s' want 0100 2 'Wrong Pass Key'", bus.oGNT, bus.oCUR_ID, bus.oLINE1);
    end
    bus.iREQ = '0;
    for (int i = 0; i < 20 && bus.oBUSY; i++) @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      checks++;
      if ({bus.oGNT, bus.oUPDATE, bus.oBUSY, bus.oCUR_ID} !== {e_gnt, e_upd, e_busy, e_id}) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d: got gnt=%b upd=%b busy=%b id=%0d want %b %b %b %0d", n,
                 bus.oGNT, bus.oUPDATE, bus.oBUSY, bus.oCUR_ID, e_gnt, e_upd, e_busy, e_id);
      end
      checks++;
      if (bus.oLINE1 !== e_l1 || bus.oLINE2 !== e_l2) begin
        errors++;
        $display("FAIL rand_text cyc %0d: got '%s'/'%s' want '%s'/'%s'", n, bus.oLINE1, bus.oLINE2, e_l1, e_l2);
      end
      bus.iREQ = bus.iREQ & ~bus.oGNT;
      for (int k = 0; k < 4; k++) begin
        if (!bus.iREQ[k] && $urandom_range(0, 7) == 0) begin
          bus.iMSG[3*k +: 3] = 3'($urandom_range(0, 7));
          bus.iREQ[k]        = 1'b1;
        end
      end
    end
    bus.iREQ = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_nonpreempt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_msg_scheduler.md
# lcd_msg_scheduler

Shares the single two-line 16x2 LCD text path between several requesters in the parking controller, such as the gate FSM, the pass-key safeguard and the occupancy counter. It picks one pending message request by fixed priority and holds the chosen text for a programmable time. A higher-priority request preempts the current message. When nothing is pending, the display returns to the idle text. Its 128-bit `oLINE1`/`oLINE2` outputs and `oUPDATE` strobe feed the existing LCD driver wrapper.

## Interface
- `N_REQ`, default 4: number of requesters. Index 0 has the highest priority.
- `HOLD_CYCLES`, default 50_000_000: display time per message, in `iCLK` cycles. Legal range is 1 .. 2^`CNT_W`.
- `CNT_W`, default 26: width of the hold counter.
- `iCLK`  in  1: system clock. This is the only clock.
- `iRST_N`  in  1: reset, asynchronous and active-low.
- `iREQ`  in  `N_REQ`: level request, one bit per requester. Each bit is held until its grant.
- `iMSG`  in  3*`N_REQ`: message code per requester. Requester k uses bits [3k+2:3k]. The code must be valid while `iREQ[k]` is high.
- `oGNT`  out  `N_REQ`: one-hot, single-cycle grant pulse.
- `oLINE1`  out  128: top line text, 16 ASCII characters, MSB = leftmost character.
- `oLINE2`  out  128: bottom line text, same format.
- `oUPDATE`  out  1: single-cycle strobe whenever `oLINE1`/`oLINE2` change.
- `oBUSY`  out  1: high while a requester's message is being held.
- `oCUR_ID`  out  clog2(`N_REQ`): index of the requester currently shown. It is 0 while idle.

## Operation
- FSM states:
  - IDLE: shows code `MSG_IDLE`.
  - SHOW: holds a granted message while the counter runs.
- IDLE:
  - If any `iREQ` bit is set, grant the lowest set index w.
  - The grant registers `oLINE1`/`oLINE2` from the ROM entry for `iMSG[w]`.
  - The grant sets `oCUR_ID`=w and loads the counter with `HOLD_CYCLES`-1. Go to SHOW.
- SHOW:
  - The counter decrements every cycle.
  - Preemption: a request with index < `oCUR_ID` is granted on the next edge and the counter reloads.
  - Equal- or lower-priority requests wait, including a re-request by the current owner.
- SHOW, counter = 0:
  - If a request is pending, grant the lowest set index directly. There is no IDLE cycle.
  - Otherwise load the idle text, set `oCUR_ID`=0 and go to IDLE.
- Every grant asserts `oGNT[w]` for exactly one cycle. The requester must drop `iREQ[w]` after seeing it.
  - If `iREQ[w]` is still high afterwards, it is treated as a new request.
- `oUPDATE` pulses with every grant and with every return to IDLE. It does not pulse on reset.
- Message codes:
  - 0 `MSG_IDLE`
  - 1 `MSG_WELCOME`
  - 2 `MSG_FULL`
  - 3 `MSG_ENTER_KEY`
  - 4 `MSG_WRONG_KEY`
  - 5 `MSG_GATE_OPEN`
  - 6–7: unused. Display 32 spaces.

## Timing
- Reset (async assert, sync release):
  - State IDLE.
  - `oLINE1`/`oLINE2` = `MSG_IDLE` text.
  - `oGNT`=0, `oUPDATE`=0, `oBUSY`=0, `oCUR_ID`=0, counter=0.
- Latency: `iREQ` sampled high at edge t produces `oGNT`, the new lines, `oUPDATE`, `oBUSY`=1 and `oCUR_ID` all valid after edge t.
  - All outputs are registered.
- A granted message stays on the display for exactly `HOLD_CYCLES` cycles, unless it is preempted.
  - With `HOLD_CYCLES`=1, each message is shown for one cycle.
- Simultaneous requests resolve in the same cycle: the lowest index wins and the rest stay pending.
- Counter expiry and a new request in the same cycle: the request is granted, with no idle text in between.
- Reset asserted mid-SHOW: all outputs go to reset values immediately.
  - Pending requests are not remembered. They are re-sampled after release.

## Structure
- Package `lcd_msg_pkg` holds:
  - message code constants `MSG_*` (3-bit);
  - the 16-character line literals for each code.
- Sub-module `lcd_msg_rom`: combinational mapping from a 3-bit code to {line1, line2}. Codes 6–7 map to spaces.
- The scheduler contains the priority encoder, FSM, hold counter and output registers.

## Test plan
Bench parameters: `N_REQ`=4, `HOLD_CYCLES`=8.
1. Reset: `oLINE1`="Parking Ready   ", `oBUSY`=0, `oGNT`=0, no `oUPDATE`.
2. Single request: `iREQ`=4'b0100 with code 4 → `oGNT`=4'b0100 for one cycle, `oCUR_ID`=2, `oLINE1`="Wrong Pass Key  ".
   - The text is held 8 cycles, then returns to idle with an `oUPDATE` pulse.
3. Simultaneous requests: `iREQ`=4'b1010 → req 1 is granted first.
   - req 3 is granted on the cycle req 1's counter expires, with no idle cycle.
4. Preemption: req 3 is shown; req 0 is raised at hold cycle 4 → grant 0 next edge, counter reloaded, req 0's text shown 8 cycles.
5. Non-preemption: req 2 is raised while req 1 is shown → no grant until req 1 expires.
6. Async reset mid-SHOW: outputs reset without a clock edge.
   - Unknown code 7 shows 32 spaces.
